// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream data/valid/ready, downstream
// data/valid/ready and the occupancy count. The slave modport is the chain's
// view of the bundle. The master modport is the environment's view.
interface pipe_reg_chain_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output occupancy
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  occupancy
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: a DEPTH-stage valid/ready register chain with bubble collapse.
// Each stage has its own ready signal, so a stalled output lets the upstream
// stages keep filling. in_ready is combinational and has no skid buffer.
// The optional synchronous flush port is compiled in when PIPE_REG_CHAIN_FLUSH_EN
// is defined.
module pipe_reg_chain #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic clk,
  input  logic reset,
`ifdef PIPE_REG_CHAIN_FLUSH_EN
  input  logic flush,
`endif
  pipe_reg_chain_if.slave bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  logic [DEPTH-1:0] ready_c;
  logic [DEPTH-1:0] src_valid_c;
  logic [WIDTH-1:0] src_data_c [DEPTH];
  logic             flush_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             deliver_c;

`ifdef PIPE_REG_CHAIN_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Per-stage ready: a stage can load if it is empty or its successor can load.
  always_comb begin
    logic r;
    r = bus.out_ready;
    ready_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      r = !valid_q[i] || r;
      ready_c[i] = r;
    end
  end

  // Source of each stage: the input port for stage 0, otherwise the previous stage.
  always_comb begin
    src_valid_c[0] = bus.in_valid && !flush_c;
    src_data_c[0]  = bus.in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      src_valid_c[i] = valid_q[i-1];
      src_data_c[i]  = data_q[i-1];
    end
  end

  // Handshake qualifiers. A flush cycle refuses new input.
  always_comb begin
    in_ready_c = ready_c[0] && !flush_c;
    accept_c   = bus.in_valid && in_ready_c;
    deliver_c  = valid_q[DEPTH-1] && bus.out_ready;
  end

  // Next state: a ready stage takes its source, and data moves only with a valid source.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = occ_q;
    if (flush_c) begin
      valid_d = '0;
      occ_d   = '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ready_c[i]) begin
          valid_d[i] = src_valid_c[i];
          if (src_valid_c[i]) begin
            data_d[i] = src_data_c[i];
          end
        end
      end
      occ_d = occ_q + OCC_W'(accept_c) - OCC_W'(deliver_c);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=8, DEPTH=4, RESET_VAL=8'h5A). A queue model
// tracks each item's stage position. The model checks the outputs on every
// cycle, and directed sequences add checks with hand-computed literal values.
module tb_pipe_reg_chain;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RV    = 8'h5A;
`ifdef PIPE_REG_CHAIN_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_r;
  logic       fl_r;
  logic       in_valid_r;
  logic [7:0] in_data_r;
  logic       out_ready_r;

  int pass_cnt;
  int total_cnt;

  pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  assign bus.in_data   = in_data_r;
  assign bus.in_valid  = in_valid_r;
  assign bus.out_ready = out_ready_r;

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .reset (rst_r),
`ifdef PIPE_REG_CHAIN_FLUSH_EN
    .flush (fl_r),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the items in flight, oldest first, with the stage each one occupies.
  int         mpos[$];
  logic [7:0] mdat[$];

  function automatic bit m_in_ready();
    return !(FLUSH_EN && fl_r) && (out_ready_r || mpos.size() < int'(DEPTH));
  endfunction

  function automatic bit m_out_valid();
    return mpos.size() > 0 && mpos[0] == int'(DEPTH) - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Model update. The oldest item advances toward the last stage, and each
  // later item advances only up to the stage just behind its predecessor.
  always @(posedge clk) begin
    bit         acc;
    bit         dlv;
    int         lim;
    int         np;
    logic [7:0] dd;
    if (!rst_r || (FLUSH_EN && fl_r)) begin
      mpos.delete();
      mdat.delete();
    end else begin
      acc = in_valid_r && m_in_ready();
      dlv = m_out_valid() && out_ready_r;
      if (dlv) begin
        np = mpos.pop_front();
        dd = mdat.pop_front();
      end
      lim = int'(DEPTH);
      for (int k = 0; k < mpos.size(); k++) begin
        np = (mpos[k] + 1 < lim) ? mpos[k] + 1 : lim - 1;
        mpos[k] = np;
        lim = np;
      end
      if (acc) begin
        mpos.push_back(0);
        mdat.push_back(in_data_r);
      end
    end
  end

  // Per-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_r === 1'b1) begin
      chk("m_in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
      chk("m_occupancy", 32'(bus.occupancy), 32'(mpos.size()));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_out_valid()));
      if (m_out_valid()) chk("m_out_data", 32'(bus.out_data), 32'(mdat[0]));
    end
  end

  // Apply one cycle of inputs just after the rising edge, then wait until the
  // middle of the cycle so the outputs can be sampled.
  task automatic drive(input logic v, input logic [7:0] d, input logic r,
                       input logic rs, input logic fl);
    @(posedge clk);
    #1;
    in_valid_r  = v;
    in_data_r   = d;
    out_ready_r = r;
    rst_r       = rs;
    fl_r        = fl;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp4 [4];
    pass_cnt = 0;
    total_cnt = 0;
    rst_r = 1'b0;
    fl_r = 1'b0;
    in_valid_r = 1'b0;
    in_data_r = '0;
    out_ready_r = 1'b0;

    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 1, 0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", 32'(bus.out_data), 32'h5A);

    // Latency: 11/22/33 presented in cycles 0..2 appear in cycles 4..6.
    for (int k = 0; k < 8; k++) begin
      drive(k < 3, 8'(8'h11 * (k + 1)), 1, 1, 0);
      chk("lat_valid", 32'(bus.out_valid), 32'(k >= 4 && k <= 6));
      if (k >= 4 && k <= 6) chk("lat_data", 32'(bus.out_data), 32'(8'h11 * (k - 3)));
    end

    // Full stall: 01..06 are offered. Only 01..04 are accepted.
    for (int k = 0; k < 6; k++) begin
      drive(1, 8'(k + 1), 0, 1, 0);
      chk("stall_in_ready", 32'(bus.in_ready), 32'(k < 4));
    end
    // Full chain with accept and deliver in the same cycle.
    drive(1, 8'h07, 1, 1, 0);
    chk("full_occupancy", 32'(bus.occupancy), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd1);
    chk("full_out_data", 32'(bus.out_data), 32'h01);
    exp4[0] = 8'h02; exp4[1] = 8'h03; exp4[2] = 8'h04; exp4[3] = 8'h07;
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h00, 1, 1, 0);
      if (k == 0) chk("simul_occupancy", 32'(bus.occupancy), 32'd4);
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_data", 32'(bus.out_data), 32'(exp4[k]));
    end
    drive(0, 8'h00, 1, 1, 0);
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // Bubble collapse with the output stalled.
    drive(1, 8'hA0, 0, 1, 0);
    drive(0, 8'h00, 0, 1, 0);
    drive(0, 8'h00, 0, 1, 0);
    drive(1, 8'hA1, 0, 1, 0);
    for (int k = 0; k < 4; k++) drive(0, 8'h00, 0, 1, 0);
    chk("bubble_occupancy", 32'(bus.occupancy), 32'd2);
    chk("bubble_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bubble_out_data", 32'(bus.out_data), 32'hA0);

    // Reset while three items are in flight.
    drive(1, 8'hB0, 0, 1, 0);
    drive(0, 8'h00, 0, 1, 0);
    chk("pre_rst_occupancy", 32'(bus.occupancy), 32'd3);
    drive(1, 8'hB1, 1, 0, 0);
    drive(0, 8'h00, 0, 1, 0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'h5A);

`ifdef PIPE_REG_CHAIN_FLUSH_EN
    drive(1, 8'hC0, 0, 1, 0);
    drive(1, 8'hC1, 0, 1, 0);
    drive(1, 8'hC2, 0, 1, 0);
    drive(1, 8'hC3, 0, 1, 1);
    chk("flush_occupancy", 32'(bus.occupancy), 32'd3);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    drive(0, 8'h00, 1, 1, 0);
    chk("post_flush_occupancy", 32'(bus.occupancy), 32'd0);
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 8'h00, 1, 1, 0);
      chk("post_flush_quiet", 32'(bus.out_valid), 32'd0);
    end
`endif

    // Mixed in_valid/out_ready pattern. The per-cycle model checks this part.
    for (int k = 0; k < 80; k++) begin
      drive((k % 3) != 1, 8'(k * 7 + 3), (k % 5) < 3, 1, 0);
    end
    for (int k = 0; k < 8; k++) drive(0, 8'h00, 1, 1, 0);
    chk("final_occupancy", 32'(bus.occupancy), 32'd0);
    chk("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, legal range 1..16.
REQ-003 SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into every stage data register on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset that is synchronous and active-low.
REQ-006 SHALL have port in_data, input, WIDTH bits: upstream data.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-008 SHALL have port in_ready, output, 1 bit: chain can accept in_data this cycle.
REQ-009 SHALL have port out_data, output, WIDTH bits: last-stage data.
REQ-010 SHALL have port out_valid, output, 1 bit: last-stage data valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 SHALL have port occupancy, output, $clog2(DEPTH+1) bits: count of valid stages.
REQ-013 SHALL have port flush, input, 1 bit, present only when PIPE_REG_CHAIN_FLUSH_EN is defined.

Function
REQ-014 SHALL hold a data register and a valid bit per stage, with stage 0 fed by the input and stage DEPTH-1 driving out_data and out_valid.
REQ-015 SHALL define stage ready as ready[i] = !valid[i] || ready[i+1], with ready[DEPTH] = out_ready; in_ready = ready[0], combinational with no registered skid.
REQ-016 SHALL accept on in_valid && in_ready, deliver on out_valid && out_ready, and advance stage i-1 into stage i when ready[i] is high.
REQ-017 SHALL clear valid[i] when ready[i] is high and stage i-1 (or input) is not valid, so bubbles collapse and a stalled chain fills all DEPTH stages.
REQ-018 SHALL leave data unchanged in any stage whose valid bit is 0 or that is stalled; out_data is don't-care when out_valid = 0.
REQ-019 SHALL give latency of exactly DEPTH cycles from acceptance to out_valid when out_ready is held high, and sustain one transfer per cycle.
REQ-020 SHALL deliver items in acceptance order with no loss or duplication under any in_valid/out_ready pattern.
REQ-021 SHALL update occupancy as occupancy + accept - deliver each cycle; simultaneous accept and deliver leaves it unchanged.
REQ-022 SHALL drive in_ready = 0 when occupancy = DEPTH and out_ready = 0, and in_ready = 1 when full with out_ready = 1, which allows a simultaneous accept and deliver.
REQ-023 SHALL, for DEPTH = 1, behave as a single register stage with in_ready = !out_valid || out_ready.

Reset
REQ-024 SHALL, on a rising clk edge with reset = 0, clear all valid bits, load all data registers with RESET_VAL, and set occupancy to 0.
REQ-025 SHALL give reset priority over all other inputs, including flush and in-flight transfers; items in flight are discarded.
REQ-026 SHALL hold out_valid = 0 and occupancy = 0 while reset is 0; in_ready SHALL follow REQ-015 (1 during reset).

Configuration
REQ-027 SHALL, with PIPE_REG_CHAIN_FLUSH_EN defined, clear all valid bits and set occupancy to 0 on a rising edge with flush = 1 while data registers hold.
REQ-028 SHALL, with PIPE_REG_CHAIN_FLUSH_EN defined, force in_ready = 0 during the flush cycle so no item is accepted; out_valid is unaffected until the edge.
REQ-029 SHALL, without PIPE_REG_CHAIN_FLUSH_EN, omit the flush port and all flush logic; behaviour is per REQ-014..026.

Verification
REQ-030 SHALL cover latency: WIDTH=8, DEPTH=4, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_valid on cycles 4,5,6 with data 0x11,0x22,0x33.
REQ-031 SHALL cover the full stall: out_ready=0, in_valid=1 for 6 cycles with 0x01..0x06 -> 0x01..0x04 accepted, in_ready=0 after 4th, occupancy=4; then out_ready=1 -> 0x01..0x04 delivered in order.
REQ-032 SHALL cover simultaneous events when full: occupancy=4, in_valid=1, out_ready=1 -> one accept and one deliver same cycle, occupancy stays 4.
REQ-033 SHALL cover bubble collapse: send 0xA0, idle 2 cycles, 0xA1, out_ready=0 -> both reach stages 3 and 2, occupancy=2, in_ready=1.
REQ-034 SHALL cover reset mid-operation: occupancy=3, reset=0 for one edge with RESET_VAL=0x5A -> next cycle out_valid=0, occupancy=0, out_data=0x5A.
REQ-035 SHALL cover flush with PIPE_REG_CHAIN_FLUSH_EN: occupancy=3, flush=1 with in_valid=1 -> in_ready=0 that cycle, next cycle occupancy=0 and out_valid=0.
